// File: rtl/draw_player_pkg.sv
// Shared VGA geometry, player defaults and helpers for the player overlay stage.
package draw_player_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  localparam int          PLAYER_W_DEF   = 32;
  localparam int          PLAYER_H_DEF   = 48;
  localparam int          GROUND_Y_DEF   = 500;
  localparam int          X_START_DEF    = 100;
  localparam int          STEP_DEF       = 4;
  localparam int          JUMP_V0_DEF    = 12;
  localparam logic [11:0] PLAYER_RGB_DEF = 12'hF80;

  typedef enum logic {
    GROUND = 1'b0,
    AIR    = 1'b1
  } player_state_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  // One frame of horizontal motion; compares are done before any add/subtract so x never wraps.
  function automatic logic [10:0] step_x(
    input logic [10:0] x,
    input logic        left,
    input logic        right,
    input logic [10:0] step,
    input logic [10:0] x_max
  );
    logic [10:0] x_new;
    x_new = x;
    if (right && !left) begin
      if (({1'b0, x} + {1'b0, step}) >= {1'b0, x_max}) x_new = x_max;
      else                                             x_new = x + step;
    end else if (left && !right) begin
      if (x <= step) x_new = '0;
      else           x_new = x - step;
    end
    return x_new;
  endfunction

endpackage

// File: rtl/draw_player_ctl.sv
// Player controller: vblank-edge frame tick, saturating x motion and the gravity jump FSM.
// Jump FSM is built only when PLAYER_JUMP_EN is defined; otherwise the sprite stays on the ground.
//
// state  | meaning
// GROUND | standing, ypos at ground row, vy = 0
// AIR    | jumping/falling, ypos -= vy and vy -= 1 each tick
module player_ctl
  import draw_player_pkg::*;
#(
  parameter int PLAYER_W = PLAYER_W_DEF,
  parameter int PLAYER_H = PLAYER_H_DEF,
  parameter int GROUND_Y = GROUND_Y_DEF,
  parameter int X_START  = X_START_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int JUMP_V0  = JUMP_V0_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        jump,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        airborne
);

  localparam logic [10:0] Y_GND  = 11'(GROUND_Y - PLAYER_H + 1);
  localparam logic [10:0] X_MAX  = 11'(HOR_PIXELS - PLAYER_W);
  localparam logic [10:0] X_RST  = 11'(X_START);
  localparam logic [10:0] STEP_X = 11'(STEP);

  logic        vblnk_q;
  logic        tick;
  logic [10:0] x_q, x_d;

  assign tick = vblnk & ~vblnk_q;

  always_comb begin
    x_d = x_q;
    if (tick) x_d = step_x(x_q, move_left, move_right, STEP_X, X_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q <= 1'b0;
      x_q     <= X_RST;
    end else begin
      vblnk_q <= vblnk;
      x_q     <= x_d;
    end
  end

  assign xpos = x_q;

`ifdef PLAYER_JUMP_EN
  player_state_t      state_q, state_d;
  logic signed [7:0]  vy_q, vy_d;
  logic [10:0]        y_q, y_d;
  logic signed [12:0] y_air;

  // y - vy in a wider signed domain so a falling (negative vy) step compares cleanly against ground
  assign y_air = $signed({2'b00, y_q}) - $signed({{5{vy_q[7]}}, vy_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GROUND;
      vy_q    <= '0;
      y_q     <= Y_GND;
    end else begin
      state_q <= state_d;
      vy_q    <= vy_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vy_d    = vy_q;
    y_d     = y_q;
    if (tick) begin
      case (state_q)
        GROUND: begin
          if (jump) begin
            state_d = AIR;
            vy_d    = 8'(JUMP_V0);
          end
        end
        AIR: begin
          if (y_air >= $signed({2'b00, Y_GND})) begin
            state_d = GROUND;
            y_d     = Y_GND;
            vy_d    = '0;
          end else begin
            y_d  = y_air[10:0];
            vy_d = vy_q - 8'sd1;
          end
        end
        default: state_d = GROUND;
      endcase
    end
  end

  always_comb begin
    airborne = (state_q == AIR);
    ypos     = y_q;
  end
`else
  logic unused_jump;
  assign unused_jump = jump;
  assign ypos        = Y_GND;
  assign airborne    = 1'b0;
`endif

endmodule

// File: rtl/draw_player.sv
// Player overlay stage: replaces background rgb inside the player box, all fields delayed one clk.
// Optional jump FSM enabled by defining PLAYER_JUMP_EN.
module draw_player
  import draw_player_pkg::*;
#(
  parameter int          PLAYER_W   = PLAYER_W_DEF,
  parameter int          PLAYER_H   = PLAYER_H_DEF,
  parameter int          GROUND_Y   = GROUND_Y_DEF,
  parameter int          X_START    = X_START_DEF,
  parameter int          STEP       = STEP_DEF,
  parameter int          JUMP_V0    = JUMP_V0_DEF,
  parameter logic [11:0] PLAYER_RGB = PLAYER_RGB_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] vga_in_hcount,
  input  logic [10:0] vga_in_vcount,
  input  logic        vga_in_hsync,
  input  logic        vga_in_vsync,
  input  logic        vga_in_hblnk,
  input  logic        vga_in_vblnk,
  input  logic [11:0] vga_in_rgb,
  output logic [10:0] vga_out_hcount,
  output logic [10:0] vga_out_vcount,
  output logic        vga_out_hsync,
  output logic        vga_out_vsync,
  output logic        vga_out_hblnk,
  output logic        vga_out_vblnk,
  output logic [11:0] vga_out_rgb,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        jump,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        airborne
);

  vga_t vga_q, vga_d;
  logic hit;

  player_ctl #(
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H),
    .GROUND_Y (GROUND_Y),
    .X_START  (X_START),
    .STEP     (STEP),
    .JUMP_V0  (JUMP_V0)
  ) u_ctl (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblnk      (vga_in_vblnk),
    .move_left  (move_left),
    .move_right (move_right),
    .jump       (jump),
    .xpos       (xpos),
    .ypos       (ypos),
    .airborne   (airborne)
  );

  // 12-bit sums so xpos+W / ypos+H cannot overflow the 11-bit counters
  always_comb begin
    hit = !vga_in_hblnk && !vga_in_vblnk
       && ({1'b0, vga_in_hcount} >= {1'b0, xpos})
       && ({1'b0, vga_in_hcount} <  ({1'b0, xpos} + 12'(PLAYER_W)))
       && ({1'b0, vga_in_vcount} >= {1'b0, ypos})
       && ({1'b0, vga_in_vcount} <  ({1'b0, ypos} + 12'(PLAYER_H)));
  end

  always_comb begin
    vga_d.hcount = vga_in_hcount;
    vga_d.vcount = vga_in_vcount;
    vga_d.hsync  = vga_in_hsync;
    vga_d.vsync  = vga_in_vsync;
    vga_d.hblnk  = vga_in_hblnk;
    vga_d.vblnk  = vga_in_vblnk;
    vga_d.rgb    = hit ? PLAYER_RGB : vga_in_rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vga_q <= '0;
    else        vga_q <= vga_d;
  end

  assign vga_out_hcount = vga_q.hcount;
  assign vga_out_vcount = vga_q.vcount;
  assign vga_out_hsync  = vga_q.hsync;
  assign vga_out_vsync  = vga_q.vsync;
  assign vga_out_hblnk  = vga_q.hblnk;
  assign vga_out_vblnk  = vga_q.vblnk;
  assign vga_out_rgb    = vga_q.rgb;

endmodule
